// File: rtl/debug_unit_pkg.sv
// Shared constants and types for the debug unit: host command bytes, FSM states, dump phases.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] ACK       = 8'h06;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned NB_BYTE        = 8;
  localparam int unsigned NB_WORD        = BYTES_PER_WORD * NB_BYTE;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    LOAD_WR,
    RUN,
    STEP,
    DUMP_ADDR,
    DUMP_LATCH,
    DUMP_SEND,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_REG,
    PH_MEM,
    PH_CNT
  } dump_phase_e;

endpackage

// File: rtl/dunit_tx_serializer.sv
// Sends a 32-bit word as 4 bytes, MSB first, over a valid/ready handshake; pulses o_done
// on the final byte transfer. Valid drops for one cycle after every transfer.
module dunit_tx_serializer
  import debug_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  output logic               o_valid,
  output logic [NB_BYTE-1:0] o_data,
  input  logic               i_ready,
  output logic               o_done
);

  logic [NB_WORD-1:0] shift_q, shift_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               gap_q, gap_d;
  logic               xfer;

  assign o_valid = busy_q & ~gap_q;
  assign o_data  = o_valid ? shift_q[NB_WORD-1 -: NB_BYTE] : '0;
  assign xfer    = o_valid & i_ready;
  assign o_done  = xfer && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    gap_d   = 1'b0;
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (xfer) begin
      shift_d = shift_q << NB_BYTE;
      cnt_d   = cnt_q + 2'd1;
      gap_d   = 1'b1;
      if (cnt_q == 2'(BYTES_PER_WORD - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller: loads imem, runs/steps the core, dumps regs + dmem over UART.
// Optional DUNIT_CYCLE_COUNT_EN appends a 32-bit enabled-cycle counter to each dump.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int unsigned        NB_REG     = 32,
  parameter int unsigned        NB_ADDR    = 5,
  parameter int unsigned        IMEM_WORDS = 128,
  parameter int unsigned        DMEM_WORDS = 32,
  parameter logic [NB_REG-1:0]  HALT_INST  = 32'hFFFF_FFFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_dunit_reg,
  input  logic [NB_REG-1:0] i_dunit_mem_data,
  output logic              o_dunit_clk_en,
  output logic              o_dunit_reset_pc,
  output logic              o_dunit_w_mem,
  output logic [NB_REG-1:0] o_dunit_addr,
  output logic [NB_REG-1:0] o_dunit_data_if
);

  localparam logic [NB_REG-1:0] REG_LAST  = NB_REG'((2 ** NB_ADDR) - 1);
  localparam logic [NB_REG-1:0] MEM_LAST  = NB_REG'(DMEM_WORDS - 1);
  localparam logic [NB_REG-1:0] IMEM_LAST = NB_REG'(IMEM_WORDS - 1);

  state_e            state_q, state_d;
  dump_phase_e       phase_q, phase_d;
  logic [NB_REG-1:0] idx_q, idx_d;
  logic [NB_REG-1:0] word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              ack_q, ack_d;
  logic              reset_pc_q, reset_pc_d;

  logic               clk_en;
  logic [NB_REG-1:0]  dump_addr;
  logic               ser_load;
  logic [NB_WORD-1:0] ser_word;
  logic               ser_valid;
  logic [7:0]         ser_data;
  logic               ser_done;
  logic [NB_WORD-1:0] cycle_word;

`ifdef DUNIT_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic        cyc_clr;

  assign cyc_clr = (state_q == IDLE) && i_rx_valid &&
                   ((i_rx_data == CMD_LOAD) || (i_rx_data == CMD_RESET));

  always_comb begin
    cyc_d = cyc_q;
    if (cyc_clr)     cyc_d = '0;
    else if (clk_en) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cyc_q <= '0;
    else         cyc_q <= cyc_d;
  end

  assign cycle_word = NB_WORD'(cyc_q);
`else
  assign cycle_word = '0;
`endif

  // Registers are indexed by number, data memory by byte address.
  assign dump_addr = (phase_q == PH_REG) ? idx_q : (idx_q << 2);

  always_comb begin
    unique case (phase_q)
      PH_REG:  ser_word = NB_WORD'(i_dunit_reg);
      PH_MEM:  ser_word = NB_WORD'(i_dunit_mem_data);
      default: ser_word = cycle_word;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    idx_d           = idx_q;
    word_d          = word_q;
    byte_cnt_d      = byte_cnt_q;
    ack_d           = ack_q & ~i_tx_ready;
    reset_pc_d      = 1'b0;
    clk_en          = 1'b0;
    o_dunit_w_mem   = 1'b0;
    o_dunit_addr    = '0;
    o_dunit_data_if = '0;
    ser_load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          unique case (i_rx_data)
            CMD_LOAD: begin
              state_d    = LOAD;
              idx_d      = '0;
              byte_cnt_d = '0;
            end
            CMD_RESET: begin
              reset_pc_d = 1'b1;
              ack_d      = 1'b1;
            end
            CMD_CONT: state_d = RUN;
            CMD_STEP: state_d = STEP;
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          word_d     = {word_q[NB_REG-9:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        o_dunit_w_mem   = 1'b1;
        o_dunit_addr    = idx_q << 2;
        o_dunit_data_if = word_q;
        idx_d           = idx_q + 1'b1;
        byte_cnt_d      = '0;
        if ((word_q == HALT_INST) || (idx_q == IMEM_LAST)) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      RUN, STEP: begin
        clk_en = ~i_halt;
        if (i_halt || (state_q == STEP)) begin
          state_d = DUMP_ADDR;
          phase_d = PH_REG;
          idx_d   = '0;
        end
      end
      DUMP_ADDR: begin
        o_dunit_addr = dump_addr;
        state_d      = DUMP_LATCH;
      end
      DUMP_LATCH: begin
        o_dunit_addr = dump_addr;
        if (!ack_q) begin
          ser_load = 1'b1;
          state_d  = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (ser_done) begin
          idx_d   = idx_q + 1'b1;
          state_d = DUMP_ADDR;
          unique case (phase_q)
            PH_REG: begin
              if (idx_q == REG_LAST) begin
                idx_d   = '0;
                phase_d = PH_MEM;
              end
            end
            PH_MEM: begin
              if (idx_q == MEM_LAST) begin
`ifdef DUNIT_CYCLE_COUNT_EN
                idx_d   = '0;
                phase_d = PH_CNT;
`else
                state_d = DONE;
`endif
              end
            end
            default: state_d = DONE;
          endcase
        end
      end
      DONE: begin
        // First DONE cycle is the mandatory idle gap after the last data byte.
        if (ack_q) begin
          if (i_tx_ready) state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      phase_q    <= PH_REG;
      idx_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      ack_q      <= 1'b0;
      reset_pc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      ack_q      <= ack_d;
      reset_pc_q <= reset_pc_d;
    end
  end

  dunit_tx_serializer u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_word  (ser_word),
    .o_valid (ser_valid),
    .o_data  (ser_data),
    .i_ready (i_tx_ready & ~ack_q),
    .o_done  (ser_done)
  );

  assign o_tx_valid       = ack_q | ser_valid;
  assign o_tx_data        = ack_q ? ACK : ser_data;
  assign o_dunit_clk_en   = clk_en;
  assign o_dunit_reset_pc = reset_pc_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: command table plus load/run/backpressure/reset sequences.
module tb_debug_unit;

  localparam int DMEM_WORDS = 32;
`ifdef DUNIT_CYCLE_COUNT_EN
  localparam int DUMP_BYTES = (32 + DMEM_WORDS) * 4 + 5;
`else
  localparam int DUMP_BYTES = (32 + DMEM_WORDS) * 4 + 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] dunit_reg;
  logic [31:0] dmem_rd;
  logic        clk_en;
  logic        rpc;
  logic        w_mem;
  logic [31:0] addr;
  logic [31:0] data_if;

  always #5 clk = ~clk;

  debug_unit #(
    .NB_REG     (32),
    .NB_ADDR    (5),
    .IMEM_WORDS (128),
    .DMEM_WORDS (DMEM_WORDS),
    .HALT_INST  (32'hFFFF_FFFF)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_rx_valid       (rx_valid),
    .i_rx_data        (rx_data),
    .o_tx_valid       (tx_valid),
    .o_tx_data        (tx_data),
    .i_tx_ready       (tx_ready),
    .i_halt           (halt),
    .i_dunit_reg      (dunit_reg),
    .i_dunit_mem_data (dmem_rd),
    .o_dunit_clk_en   (clk_en),
    .o_dunit_reset_pc (rpc),
    .o_dunit_w_mem    (w_mem),
    .o_dunit_addr     (addr),
    .o_dunit_data_if  (data_if)
  );

  // Pipeline model: combinational regfile, 1-cycle-latency data memory.
  logic [31:0] reg_m  [32];
  logic [31:0] dmem_m [32];
  assign dunit_reg = reg_m[addr[4:0]];
  always @(posedge clk) dmem_rd <= dmem_m[addr[6:2]];

  logic [7:0] tx_q[$];
  int clk_en_cnt = 0, rpc_cnt = 0, wmem_cnt = 0, gap_viol = 0;
  logic last_xfer = 1'b0;

  always @(posedge clk) begin
    if (tx_valid && last_xfer) gap_viol++;
    last_xfer <= tx_valid & tx_ready & ~rst;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (clk_en) clk_en_cnt++;
    if (rpc) rpc_cnt++;
    if (w_mem) wmem_cnt++;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] exp_q[$];

  task automatic build_exp(input logic [31:0] cnt);
    logic [31:0] w;
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      w = reg_m[r];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    for (int k = 0; k < DMEM_WORDS; k++) begin
      w = dmem_m[k];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
`ifdef DUNIT_CYCLE_COUNT_EN
    for (int b = 3; b >= 0; b--) exp_q.push_back(cnt[8*b +: 8]);
`else
    if (cnt == 32'hDEAD_BEEF) $display("note: unexpected cycle argument");
`endif
    exp_q.push_back(8'h06);
  endtask

  task automatic chk_stream(input string name, input int base, input logic [31:0] cnt);
    int bad;
    build_exp(cnt);
    bad = 0;
    chk({name, "_len"}, tx_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= tx_q.size() || tx_q[base + i] !== exp_q[i]) bad++;
    chk({name, "_bytes_wrong"}, bad, 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         exp_rpc;
    int         exp_bytes;
    int         exp_clk_en;
    bit         is_dump;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b_tx, b_ce, b_rpc, b_wm;
    logic [7:0] held;
    bit ok, stable;

    vecs[0] = '{8'h52, 1, 1, 0, 1'b0};
    vecs[1] = '{8'h00, 0, 0, 0, 1'b0};
    vecs[2] = '{8'h72, 0, 0, 0, 1'b0};
    vecs[3] = '{8'h43, 0, DUMP_BYTES, 0, 1'b1};
    vecs[4] = '{8'h53, 0, DUMP_BYTES, 0, 1'b1};
    vecs[5] = '{8'h06, 0, 0, 0, 1'b0};

    for (int i = 0; i < 32; i++) begin
      reg_m[i]  = {8'(i), 8'hA5, 8'(i * 7), 8'h3C ^ 8'(i)};
      dmem_m[i] = {8'hD0, 8'(i * 3), 8'h5A, 8'(255 - i)};
    end

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; halt = 1'b1;
    cycles(4);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_clk_en", clk_en, 0);
    chk("reset_rpc", rpc, 0);
    chk("reset_wmem", w_mem, 0);
    chk("reset_addr", addr, 0);
    chk("reset_data_if", data_if, 0);
    rst = 1'b0;
    cycles(2);

    // Command table, halt held high: dumps carry zero cycles.
    for (int v = 0; v < 6; v++) begin
      b_tx = tx_q.size(); b_ce = clk_en_cnt; b_rpc = rpc_cnt;
      send_byte(vecs[v].cmd);
      cycles(1000);
      chk($sformatf("tbl%0d_rpc", v), rpc_cnt - b_rpc, vecs[v].exp_rpc);
      chk($sformatf("tbl%0d_bytes", v), tx_q.size() - b_tx, vecs[v].exp_bytes);
      chk($sformatf("tbl%0d_clk_en", v), clk_en_cnt - b_ce, vecs[v].exp_clk_en);
      if (vecs[v].exp_bytes > 0 && tx_q.size() > 0)
        chk($sformatf("tbl%0d_last", v), tx_q[tx_q.size() - 1], 8'h06);
      if (vecs[v].is_dump) chk_stream($sformatf("tbl%0d_dump", v), b_tx, 32'd0);
    end

    // Load two words.
    halt = 1'b0;
    b_tx = tx_q.size(); b_ce = clk_en_cnt; b_wm = wmem_cnt;
    send_byte(8'h4C);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    chk("load0_wmem", w_mem, 1);
    chk("load0_addr", addr, 32'd0);
    chk("load0_data", data_if, 32'h2001_0005);
    @(negedge clk);
    chk("load0_wmem_one_cycle", w_mem, 0);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    chk("load1_wmem", w_mem, 1);
    chk("load1_addr", addr, 32'd4);
    chk("load1_data", data_if, 32'hFFFF_FFFF);
    cycles(10);
    chk("load_wmem_count", wmem_cnt - b_wm, 2);
    chk("load_ack_count", tx_q.size() - b_tx, 1);
    if (tx_q.size() > b_tx) chk("load_ack", tx_q[b_tx], 8'h06);
    chk("load_clk_en", clk_en_cnt - b_ce, 0);

    // 'R' pulse.
    b_tx = tx_q.size(); b_ce = clk_en_cnt;
    send_byte(8'h52);
    chk("rpc_high", rpc, 1);
    @(negedge clk);
    chk("rpc_low", rpc, 0);
    cycles(10);
    chk("rpc_ack_count", tx_q.size() - b_tx, 1);
    if (tx_q.size() > b_tx) chk("rpc_ack", tx_q[b_tx], 8'h06);
    chk("rpc_clk_en", clk_en_cnt - b_ce, 0);

    // 'C' with halt rising after 10 enabled cycles.
    b_tx = tx_q.size(); b_ce = clk_en_cnt;
    send_byte(8'h43);
    chk("run_first_clk_en", clk_en, 1);
    cycles(10);
    halt = 1'b1;
    #1;
    chk("run_halt_clk_en", clk_en, 0);
    cycles(1000);
    chk("run_clk_en_count", clk_en_cnt - b_ce, 10);
    chk_stream("run_dump", b_tx, 32'd10);

    // Backpressure mid-dump.
    b_tx = tx_q.size();
    send_byte(8'h53);
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (tx_q.size() - b_tx >= 20 && tx_valid) ok = 1'b1;
    end
    chk("bp_reached", ok, 1);
    tx_ready = 1'b0;
    held = tx_data;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== held) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    tx_ready = 1'b1;
    cycles(1000);
    chk_stream("bp_dump", b_tx, 32'd10);
    chk("tx_gap_violations", gap_viol, 0);

    // Reset during load, then 'R' and a single step.
    b_wm = wmem_cnt;
    send_byte(8'h4C); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_wmem", w_mem, 0);
    send_byte(8'h00); send_byte(8'h00);
    b_tx = tx_q.size();
    send_byte(8'h52);
    chk("abort_rpc", rpc, 1);
    cycles(10);
    chk("abort_no_write", wmem_cnt - b_wm, 0);
    chk("abort_ack_count", tx_q.size() - b_tx, 1);
    halt = 1'b0;
    b_tx = tx_q.size(); b_ce = clk_en_cnt;
    send_byte(8'h53);
    chk("step_clk_en", clk_en, 1);
    @(negedge clk);
    chk("step_clk_en_off", clk_en, 0);
    cycles(1000);
    chk("step_clk_en_count", clk_en_cnt - b_ce, 1);
    chk_stream("step_dump", b_tx, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
